keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Parametrised matrix-keypad scanner; successor of the fixed 4x4 scanner.
//  Drives rows active-low one-hot and samples synchronised active-low columns.
//  Debounces per scan frame, rejects multi-key frames, emits press/release
//  pulses and optional typematic repeat. Feeds the calculator/stopwatch input FSM.
// PARAMETERS
//  ROWS                 4      number of row lines (>=2)
//  COLS                 4      number of column lines (>=2)
//  SCAN_TICKS           10000  clk cycles each row is driven (>=4)
//  DEBOUNCE_FRAMES      16     consecutive equal frames to accept press/release (>=1)
//  REPEAT_DELAY_FRAMES  625    held frames before first repeat; 0 disables repeat
//  REPEAT_RATE_FRAMES   125    frames between subsequent repeats (>=1)
//  LEGACY_MAP           1      1: 4x4 legacy code map (needs ROWS=COLS=4); 0: raw index
// PORTS
//  clk          in   1     system clock
//  rst_n        in   1     asynchronous reset, active low
//  row          out  ROWS  row drive, active-low one-hot
//  col          in   COLS  column sense, active low, asynchronous to clk
//  key_code     out  CW    code of the accepted key, CW=max(1,$clog2(ROWS*COLS))
//  key_press    out  1     1-cycle pulse: new press or repeat
//  key_repeat   out  1     1-cycle pulse, coincident with key_press when it is a repeat
//  key_release  out  1     1-cycle pulse: accepted release
//  key_held     out  1     level: a key is accepted and held
//  multi_key    out  1     level: the last frame had >=2 keys down
// BEHAVIOUR
//  Reset (async, rst_n=0): row all 1s; key_code=0; all pulses, key_held and multi_key 0;
//   counters cleared; FSM IDLE. Reset mid-scan or mid-hold: no release pulse is emitted.
//  Sync: col passes through 2 flops before use (2-cycle latency).
//  Scan: row index r starts at 0 on the first cycle after reset release; row[r]=0.
//   The tick counter runs 0..SCAN_TICKS-1. At tick SCAN_TICKS-1 the synchronised col
//   is sampled for row r, then r advances (wraps ROWS-1 -> 0). A frame is ROWS*SCAN_TICKS
//   cycles; frame_done is an internal pulse 1 cycle after sampling row ROWS-1.
//  Frame result: bit count of pressed (col=0) samples across all rows.
//   0 -> NONE; 1 -> SINGLE(idx=r*COLS+c); >=2 -> MULTI. multi_key updates on frame_done.
//  Code: LEGACY_MAP=0 -> key_code=idx. LEGACY_MAP=1 -> row0:1,2,3,10; row1:4,5,6,11;
//   row2:7,8,9,12; row3:15,0,14,13.
//  FSM (advances only on frame_done):
//   IDLE: SINGLE c -> CAND(cand=c,cnt=1); if DEBOUNCE_FRAMES=1 go straight to accept.
//    NONE/MULTI: stay.
//   CAND: SINGLE==cand -> cnt++; when cnt==DEBOUNCE_FRAMES accept: key_code<=code(cand),
//    key_press pulse, key_held=1, rep=0, rel=0 -> HELD. Any other result -> IDLE, no output.
//   HELD: SINGLE==key -> rel=0, rep++; repeat fires when rep==REPEAT_DELAY_FRAMES, then
//    every REPEAT_RATE_FRAMES frames (key_press+key_repeat pulses).
//    NONE or a different SINGLE -> rel++; at rel==DEBOUNCE_FRAMES: key_release pulse,
//    key_held=0 -> IDLE. key_code keeps its last value.
//    MULTI -> frozen: rep and rel unchanged, no pulses.
//  Counters saturate; no wrap. A rollover to a new key requires a release first.
//  Pulses are registered, 1 clk wide, and asserted in the cycle after frame_done.
// TESTING (ROWS=COLS=4, SCAN_TICKS=4, DEBOUNCE_FRAMES=3, REPEAT 4/2, LEGACY_MAP=1)
//  1 Reset: rst_n low mid-frame -> row=4'hF, all outputs 0; after release row cycles
//    E,D,B,7 with each value held 4 clk.
//  2 Hold row1/col2 (the '6' key) for 6 frames -> one key_press at frame 3 with key_code=6,
//    key_held=1; release for 3 frames -> one key_release, key_held=0.
//  3 Bounce: key down 2 frames, up 1, down 2 -> no key_press; FSM returns to IDLE.
//  4 Two keys, row0/col0 and row3/col3, held -> multi_key=1, no press; releasing to
//    row0/col0 only -> press of code 1 after 3 frames.
//  5 Repeat: row3/col1 held 12 frames -> presses at frames 3,7,9,11; repeats carry
//    key_code=0 and key_repeat=1.
//  6 LEGACY_MAP=0, ROWS=3, COLS=5: row2/col4 -> key_code=14 (CW=4); rows cycle 6,5,3.

Source files
------------

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: active-low one-hot row drive, 2-flop column sync,
// frame-level debounce with multi-key rejection, press/release/typematic pulses.
module keypad_scanner #(
  parameter int ROWS                = 4,
  parameter int COLS                = 4,
  parameter int SCAN_TICKS          = 10000,
  parameter int DEBOUNCE_FRAMES     = 16,
  parameter int REPEAT_DELAY_FRAMES = 625,
  parameter int REPEAT_RATE_FRAMES  = 125,
  parameter int LEGACY_MAP          = 1,
  localparam int CW = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col,
  output logic [CW-1:0]   key_code,
  output logic            key_press,
  output logic            key_repeat,
  output logic            key_release,
  output logic            key_held,
  output logic            multi_key
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW    = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RPMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES
                                                                    : REPEAT_RATE_FRAMES;
  localparam int PW    = (RPMAX > 0) ? $clog2(RPMAX + 1) : 1;
  localparam bit REP_EN = (REPEAT_DELAY_FRAMES != 0);
  // legacy 4x4 code per raw index, nibble i = code of index i
  localparam logic [63:0] LEGACY_LUT = 64'hDE0F_C987_B654_A321;

  localparam logic [1:0] HITS_NONE   = 2'd0;
  localparam logic [1:0] HITS_SINGLE = 2'd1;
  localparam logic [1:0] HITS_MULTI  = 2'd2;

  typedef enum logic [1:0] {IDLE, CAND, HELD} state_t;

  typedef struct packed {
    logic [1:0]    hits;   // saturates at 2
    logic [CW-1:0] idx;    // index of the first pressed key seen
  } frame_t;

  function automatic logic [CW-1:0] map_code(input logic [CW-1:0] i);
    logic [3:0] v;
    v = LEGACY_LUT[(int'(i) & 15)*4 +: 4];
    if (LEGACY_MAP == 0) return i;
    return CW'(v);
  endfunction

  // ---------------- scan ----------------
  logic [1:0][COLS-1:0] col_pipe;
  logic                 st_q;
  logic [TW-1:0]        tick_q;
  logic [RW-1:0]        r_q;
  frame_t               acc_q, acc_nxt, res_q;
  logic                 frame_done_q;
  logic                 sample;
  logic [1:0]           row_hits;
  logic [CW-1:0]        row_c, row_idx;
  logic [2:0]           hit_sum;

  assign sample = st_q && (tick_q == TW'(SCAN_TICKS-1));
  assign row    = st_q ? ~(ROWS'(1) << r_q) : '1;

  always_comb begin
    row_hits = HITS_NONE;
    row_c    = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!col_pipe[1][c]) begin
        row_c = CW'(c);
        if (row_hits != HITS_MULTI) row_hits = row_hits + 2'd1;
      end
    end
    row_idx     = CW'(int'(r_q) * COLS + int'(row_c));
    hit_sum     = {1'b0, acc_q.hits} + {1'b0, row_hits};
    acc_nxt     = acc_q;
    acc_nxt.hits = (hit_sum >= 3'd2) ? HITS_MULTI : hit_sum[1:0];
    if (acc_q.hits == HITS_NONE) acc_nxt.idx = row_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_pipe     <= '1;
      st_q         <= 1'b0;
      tick_q       <= '0;
      r_q          <= '0;
      acc_q        <= '0;
      res_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_pipe     <= {col_pipe[0], col};
      st_q         <= 1'b1;
      frame_done_q <= 1'b0;
      if (st_q) begin
        if (sample) begin
          tick_q <= '0;
          if (r_q == RW'(ROWS-1)) begin
            r_q          <= '0;
            res_q        <= acc_nxt;
            acc_q        <= '0;
            frame_done_q <= 1'b1;
          end else begin
            r_q   <= r_q + 1'b1;
            acc_q <= acc_nxt;
          end
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
    end
  end

  // ---------------- key FSM ----------------
  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic [PW-1:0] rep_q, rep_d, rep_tgt;
  logic          rep_ph_q, rep_ph_d;
  logic [CW-1:0] key_idx_q, key_idx_d, code_q, code_d;
  logic          press_q, press_d, repeat_q, repeat_d, release_q, release_d;
  logic          held_q, held_d, multi_q, multi_d;
  logic          single, same, accept;

  assign single  = (res_q.hits == HITS_SINGLE);
  assign same    = single && (res_q.idx == key_idx_q);
  assign rep_tgt = rep_ph_q ? PW'(REPEAT_RATE_FRAMES) : PW'(REPEAT_DELAY_FRAMES);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    rep_d     = rep_q;
    rep_ph_d  = rep_ph_q;
    key_idx_d = key_idx_q;
    code_d    = code_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    held_d    = held_q;
    multi_d   = multi_q;
    accept    = 1'b0;
    if (frame_done_q) begin
      multi_d = (res_q.hits == HITS_MULTI);
      case (state_q)
        IDLE: if (single) begin
          key_idx_d = res_q.idx;
          cnt_d     = DW'(1);
          if (DEBOUNCE_FRAMES == 1) accept = 1'b1;
          else                      state_d = CAND;
        end
        CAND: if (same) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == DW'(DEBOUNCE_FRAMES)) accept = 1'b1;
        end else begin
          state_d = IDLE;
        end
        HELD: if (same) begin
          rel_d = '0;
          if (REP_EN && rep_q != rep_tgt) rep_d = rep_q + 1'b1;
          if (REP_EN && rep_d == rep_tgt) begin
            press_d  = 1'b1;
            repeat_d = 1'b1;
            rep_d    = '0;
            rep_ph_d = 1'b1;
          end
        end else if (res_q.hits != HITS_MULTI) begin
          rel_d = rel_q + 1'b1;
          if (rel_d == DW'(DEBOUNCE_FRAMES)) begin
            release_d = 1'b1;
            held_d    = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        code_d   = map_code(key_idx_d);
        press_d  = 1'b1;
        held_d   = 1'b1;
        rep_d    = '0;
        rep_ph_d = 1'b0;
        rel_d    = '0;
        state_d  = HELD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rel_q     <= '0;
      rep_q     <= '0;
      rep_ph_q  <= 1'b0;
      key_idx_q <= '0;
      code_q    <= '0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      rep_q     <= rep_d;
      rep_ph_q  <= rep_ph_d;
      key_idx_q <= key_idx_d;
      code_q    <= code_d;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
      held_q    <= held_d;
      multi_q   <= multi_d;
    end
  end

  assign key_code    = code_q;
  assign key_press   = press_q;
  assign key_repeat  = repeat_q;
  assign key_release = release_q;
  assign key_held    = held_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model driven from the row outputs,
// expected press/release events queued with the stimulus and popped on DUT pulses.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4x4 legacy instance
  logic [3:0] row, col, key_code;
  logic key_press, key_repeat, key_release, key_held, multi_key;
  logic [3:0][3:0] keys = '0;

  // 3x5 raw-index instance
  logic [2:0] row2;
  logic [4:0] col2;
  logic [3:0] key_code2;
  logic key_press2, key_repeat2, key_release2, key_held2, multi_key2;
  logic [2:0][4:0] keys2 = '0;

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_TICKS(4), .DEBOUNCE_FRAMES(3),
    .REPEAT_DELAY_FRAMES(4), .REPEAT_RATE_FRAMES(2), .LEGACY_MAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
    .key_press(key_press), .key_repeat(key_repeat), .key_release(key_release),
    .key_held(key_held), .multi_key(multi_key));

  keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_TICKS(4), .DEBOUNCE_FRAMES(3),
    .REPEAT_DELAY_FRAMES(4), .REPEAT_RATE_FRAMES(2), .LEGACY_MAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .row(row2), .col(col2), .key_code(key_code2),
    .key_press(key_press2), .key_repeat(key_repeat2), .key_release(key_release2),
    .key_held(key_held2), .multi_key(multi_key2));

  // a pressed key shorts its column low while its row is driven low
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++) if (!row[r]) col = col & ~keys[r];
    col2 = '1;
    for (int r = 0; r < 3; r++) if (!row2[r]) col2 = col2 & ~keys2[r];
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       rel;
    logic       rep;
    logic [3:0] code;
  } ev_t;

  ev_t sb[$];
  logic [3:0] sb2[$];

  function automatic ev_t mk(input logic rel, input logic rep, input logic [3:0] code);
    ev_t e;
    e.rel = rel; e.rep = rep; e.code = code;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (key_press || key_release)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {28'd0, key_press, key_release, key_repeat, key_held}, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_press",   key_press,   !e.rel);
        chk("ev_release", key_release, e.rel);
        chk("ev_repeat",  key_repeat,  e.rep);
        chk("ev_code",    key_code,    e.code);
        chk("ev_held",    key_held,    !e.rel);
      end
    end
    if (rst_n && key_press2) begin
      if (sb2.size() == 0) begin
        chk("d2_unexpected_press", {28'd0, key_code2}, 32'hFFFF);
      end else begin
        logic [3:0] c;
        c = sb2.pop_front();
        chk("d2_code", key_code2, c);
        chk("d2_held", key_held2, 1'b1);
      end
    end
  end

  function automatic bit in_r0(input bit d2);
    return d2 ? (row2 == 3'b110) : (row == 4'hE);
  endfunction

  // advance to the start of the n-th next frame (row 0, tick 0)
  task automatic frames(input int n, input bit d2 = 1'b0);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      while (in_r0(d2) && t < 200) begin @(negedge clk); t++; end
      while (!in_r0(d2) && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("frame_timeout", t, 0);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] er;
    logic [2:0] er2;
    // reset state
    cycles(3);
    chk("rst_row", row, 4'hF);
    chk("rst_code", key_code, 4'h0);
    chk("rst_pulses", {key_press, key_repeat, key_release}, 3'b000);
    chk("rst_held", key_held, 1'b0);
    chk("rst_multi", multi_key, 1'b0);
    chk("rst_row2", row2, 3'b111);
    rst_n = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      er = ~(4'b0001 << (i / 4));
      chk("row_seq", row, er);
      if (i < 12) begin
        er2 = ~(3'b001 << (i / 4));
        chk("row2_seq", row2, er2);
      end
    end
    // mid-frame reset
    cycles(5);
    rst_n = 1'b0;
    #1;
    chk("midrst_row", row, 4'hF);
    chk("midrst_out", {key_code, key_press, key_release, key_held, multi_key}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    frames(1);

    // '6' held 6 frames, released 3
    keys[1][2] = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 4'd6));
    frames(6);
    chk("t2_held", key_held, 1'b1);
    chk("t2_code", key_code, 4'd6);
    keys = '0;
    sb.push_back(mk(1'b1, 1'b0, 4'd6));
    frames(5);
    chk("t2_released", key_held, 1'b0);
    chk("t2_sb_empty", sb.size(), 0);

    // bounce: 2 down, 1 up, 2 down
    keys[1][2] = 1'b1; frames(2);
    keys = '0;         frames(1);
    keys[1][2] = 1'b1; frames(2);
    keys = '0;         frames(4);
    chk("t3_no_hold", key_held, 1'b0);

    // two keys, then one
    keys[0][0] = 1'b1; keys[3][3] = 1'b1;
    frames(4);
    cycles(2);
    chk("t4_multi", multi_key, 1'b1);
    chk("t4_no_hold", key_held, 1'b0);
    keys[3][3] = 1'b0;
    sb.push_back(mk(1'b0, 1'b0, 4'd1));
    frames(3);
    cycles(2);
    chk("t4_multi_clr", multi_key, 1'b0);
    chk("t4_held", key_held, 1'b1);
    keys = '0;
    sb.push_back(mk(1'b1, 1'b0, 4'd1));
    frames(5);
    chk("t4_sb_empty", sb.size(), 0);

    // typematic repeat on row3/col1 ('0')
    keys[3][1] = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 4'd0));
    sb.push_back(mk(1'b0, 1'b1, 4'd0));
    sb.push_back(mk(1'b0, 1'b1, 4'd0));
    sb.push_back(mk(1'b0, 1'b1, 4'd0));
    frames(12);
    keys = '0;
    sb.push_back(mk(1'b1, 1'b0, 4'd0));
    frames(5);
    chk("t5_sb_empty", sb.size(), 0);

    // reset while holding: no release afterwards
    keys[1][2] = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 4'd6));
    frames(4);
    cycles(6);
    chk("t7_held", key_held, 1'b1);
    chk("t7_code", key_code, 4'd6);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_row", row, 4'hF);
    chk("t7_rst_code", key_code, 4'd0);
    chk("t7_rst_held", key_held, 1'b0);
    keys = '0;
    cycles(2);
    rst_n = 1'b1;
    frames(6);
    chk("t7_sb_empty", sb.size(), 0);
    chk("t7_no_hold", key_held, 1'b0);

    // 3x5 raw map: row2/col4 -> 14
    frames(1, 1'b1);
    keys2[2][4] = 1'b1;
    sb2.push_back(4'd14);
    frames(5, 1'b1);
    chk("t6_held", key_held2, 1'b1);
    keys2 = '0;
    frames(5, 1'b1);
    chk("t6_sb_empty", sb2.size(), 0);
    chk("t6_released", key_held2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
